// File: rtl/bcd_counter_chain.sv
// Synchronous cascade of modulo-MODULUS digits with up/down count, parallel load and set/clear pairs.
// Optional saturating mode: define BCD_COUNTER_CHAIN_SAT_EN to hold at the terminal state instead of wrapping.
module bcd_counter_chain #(
   parameter int unsigned DIGITS  = 4,
   parameter int unsigned MODULUS = 10
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  r0_1,
   input  logic                  r0_2,
   input  logic                  r9_1,
   input  logic                  r9_2,
   input  logic                  load,
   input  logic [4*DIGITS-1:0]   load_val,
   input  logic                  en,
   input  logic                  up_dn,
   output logic [4*DIGITS-1:0]   count,
   output logic                  carry_out
);

   localparam logic [3:0] MAXV = 4'(MODULUS - 1);
   localparam logic [4:0] MOD5 = 5'(MODULUS);

   logic [4*DIGITS-1:0] r_count;
   logic [4*DIGITS-1:0] w_next;
   logic [DIGITS:0]     w_low_max;
   logic [DIGITS:0]     w_low_zero;
   logic                w_acc_max;
   logic                w_acc_zero;
   logic                w_set;
   logic                w_clr;
   logic                w_en;
   logic                w_terminal;
   logic                w_step_ok;
   logic [3:0]          w_dig;
   logic [3:0]          w_fld;

   assign w_set = r9_1 & r9_2;
   assign w_clr = r0_1 & r0_2;
   assign w_en  = en & rst_n;

   // w_low_max[k]: digits 0..k-1 all at MODULUS-1; index DIGITS is the whole chain
   always_comb begin
      w_low_max  = '0;
      w_low_zero = '0;
      w_acc_max  = 1'b1;
      w_acc_zero = 1'b1;
      for (int unsigned k = 0; k < DIGITS; k++) begin
         w_low_max[k]  = w_acc_max;
         w_low_zero[k] = w_acc_zero;
         w_acc_max     = w_acc_max  & (r_count[4*k +: 4] == MAXV);
         w_acc_zero    = w_acc_zero & (r_count[4*k +: 4] == 4'd0);
      end
      w_low_max[DIGITS]  = w_acc_max;
      w_low_zero[DIGITS] = w_acc_zero;
   end

   assign w_terminal = up_dn ? w_low_max[DIGITS] : w_low_zero[DIGITS];
   assign carry_out  = w_en & w_terminal;

`ifdef BCD_COUNTER_CHAIN_SAT_EN
   assign w_step_ok = ~w_terminal;
`else
   assign w_step_ok = 1'b1;
`endif

   always_comb begin
      w_next = r_count;
      w_dig  = '0;
      w_fld  = '0;
      if (w_set) begin
         for (int unsigned k = 0; k < DIGITS; k++) begin
            w_next[4*k +: 4] = MAXV;
         end
      end else if (w_clr) begin
         w_next = '0;
      end else if (load) begin
         for (int unsigned k = 0; k < DIGITS; k++) begin
            w_fld            = load_val[4*k +: 4];
            w_next[4*k +: 4] = ({1'b0, w_fld} >= MOD5) ? MAXV : w_fld;
         end
      end else if (w_en && w_step_ok) begin
         for (int unsigned k = 0; k < DIGITS; k++) begin
            w_dig = r_count[4*k +: 4];
            if (up_dn && w_low_max[k]) begin
               w_next[4*k +: 4] = (w_dig == MAXV) ? 4'd0 : w_dig + 4'd1;
            end else if (!up_dn && w_low_zero[k]) begin
               w_next[4*k +: 4] = (w_dig == 4'd0) ? MAXV : w_dig - 4'd1;
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_count <= '0;
      end else begin
         r_count <= w_next;
      end
   end

   assign count = r_count;

endmodule

// File: tb/tb_bcd_counter_chain.sv
// Self-checking bench: a 2-digit decimal chain and a 3-digit modulo-6 chain share the control inputs.
module tb_bcd_counter_chain;

`ifdef BCD_COUNTER_CHAIN_SAT_EN
   localparam bit SAT = 1'b1;
`else
   localparam bit SAT = 1'b0;
`endif

   logic        clk;
   logic        rst_n, r0_1, r0_2, r9_1, r9_2, load, en, up_dn;
   logic [7:0]  load_val_a;
   logic [11:0] load_val_b;
   logic [7:0]  count_a;
   logic [11:0] count_b;
   logic        carry_a, carry_b;

   int n_pass  = 0;
   int n_total = 0;

   bcd_counter_chain #(.DIGITS(2), .MODULUS(10)) u_dut_a (
      .clk(clk), .rst_n(rst_n), .r0_1(r0_1), .r0_2(r0_2), .r9_1(r9_1), .r9_2(r9_2),
      .load(load), .load_val(load_val_a), .en(en), .up_dn(up_dn),
      .count(count_a), .carry_out(carry_a)
   );

   bcd_counter_chain #(.DIGITS(3), .MODULUS(6)) u_dut_b (
      .clk(clk), .rst_n(rst_n), .r0_1(r0_1), .r0_2(r0_2), .r9_1(r9_1), .r9_2(r9_2),
      .load(load), .load_val(load_val_b), .en(en), .up_dn(up_dn),
      .count(count_b), .carry_out(carry_b)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic       rst_n, r0_1, r0_2, r9_1, r9_2, load;
      logic [7:0] lv;
      logic       en, up_dn;
      logic       exp_carry;
      logic [7:0] exp_count;
      string      name;
   } vec_t;

   typedef struct {
      logic [11:0] exp;
      bit          dut_b;
      string       name;
   } sb_t;

   sb_t  sb_q[$];
   vec_t tbl[$];

   function automatic vec_t mk(input logic rs, a0, b0, a9, b9, ld, input logic [7:0] lv,
                               input logic e, ud, ec, input logic [7:0] ecnt, input string nm);
      vec_t v;
      v.rst_n = rs; v.r0_1 = a0; v.r0_2 = b0; v.r9_1 = a9; v.r9_2 = b9; v.load = ld;
      v.lv = lv; v.en = e; v.up_dn = ud; v.exp_carry = ec; v.exp_count = ecnt; v.name = nm;
      return v;
   endfunction

   function automatic logic [7:0] bcd2(input int v);
      return {4'(v / 10), 4'(v % 10)};
   endfunction

   function automatic logic [11:0] pack6(input int v);
      return {4'((v / 36) % 6), 4'((v / 6) % 6), 4'(v % 6)};
   endfunction

   function automatic int next_b(input int v, input bit ud);
      bit term;
      term = ud ? (v == 215) : (v == 0);
      if (term && SAT) return v;
      return ud ? (v + 1) % 216 : (v + 215) % 216;
   endfunction

   task automatic check(input string nm, input logic [11:0] act, input logic [11:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h", nm, act, exp);
   endtask

   task automatic pop_check();
      sb_t e;
      if (sb_q.size() == 0) begin
         check("scoreboard_empty", 12'h001, 12'h000);
      end else begin
         e = sb_q.pop_front();
         if (e.dut_b) check(e.name, count_b, e.exp);
         else         check(e.name, {4'h0, count_a}, e.exp);
      end
   endtask

   // Drive one cycle on the decimal chain; carry is checked before the edge, count after.
   task automatic step_a(input vec_t v);
      @(negedge clk);
      rst_n = v.rst_n; r0_1 = v.r0_1; r0_2 = v.r0_2; r9_1 = v.r9_1; r9_2 = v.r9_2;
      load = v.load; load_val_a = v.lv; en = v.en; up_dn = v.up_dn;
      #1;
      check({v.name, "_carry"}, {11'd0, carry_a}, {11'd0, v.exp_carry});
      sb_q.push_back('{exp: {4'h0, v.exp_count}, dut_b: 1'b0, name: v.name});
      @(posedge clk);
      #1;
      pop_check();
   endtask

   task automatic step_b(input logic rs, e, ud, input logic ec, input logic [11:0] ecnt,
                         input string nm);
      @(negedge clk);
      rst_n = rs; r0_1 = 1'b0; r0_2 = 1'b0; r9_1 = 1'b0; r9_2 = 1'b0;
      load = 1'b0; load_val_b = '0; en = e; up_dn = ud;
      #1;
      check({nm, "_carry"}, {11'd0, carry_b}, {11'd0, ec});
      sb_q.push_back('{exp: ecnt, dut_b: 1'b1, name: nm});
      @(posedge clk);
      #1;
      pop_check();
   endtask

   initial begin
      int          mb;
      logic [7:0]  dw;
      logic [7:0]  uw;
      logic [11:0] bw;
      logic [11:0] bw2;

      rst_n = 1'b0; r0_1 = 1'b0; r0_2 = 1'b0; r9_1 = 1'b0; r9_2 = 1'b0;
      load = 1'b0; load_val_a = '0; load_val_b = '0; en = 1'b0; up_dn = 1'b1;

      dw = SAT ? 8'h00 : 8'h99;
      uw = SAT ? 8'h99 : 8'h00;

      //            rs r0a r0b r9a r9b ld  lv    en ud  c  count
      tbl.push_back(mk(1, 1, 1, 0, 0, 0, 8'h00, 0, 1, 0, 8'h00, "clr"));
      tbl.push_back(mk(1, 0, 0, 0, 0, 0, 8'h00, 1, 0, 1, dw,    "dn_wrap"));
      tbl.push_back(mk(1, 0, 0, 0, 0, 1, 8'h99, 0, 0, 0, 8'h99, "ld99"));
      tbl.push_back(mk(1, 0, 0, 0, 0, 0, 8'h00, 1, 0, 0, 8'h98, "dn98"));
      tbl.push_back(mk(1, 0, 0, 0, 0, 0, 8'h00, 1, 0, 0, 8'h97, "dn97"));
      tbl.push_back(mk(1, 0, 0, 0, 0, 1, 8'h37, 0, 1, 0, 8'h37, "ld37"));
      tbl.push_back(mk(1, 1, 0, 0, 0, 0, 8'h00, 1, 1, 0, 8'h38, "r0_single"));
      tbl.push_back(mk(1, 1, 1, 0, 0, 0, 8'h00, 1, 1, 0, 8'h00, "r0_pair"));
      tbl.push_back(mk(1, 1, 1, 1, 1, 0, 8'h00, 0, 1, 0, 8'h99, "r9_beats_r0"));
      tbl.push_back(mk(1, 0, 0, 0, 0, 0, 8'h00, 0, 1, 0, 8'h99, "hold_en0"));
      tbl.push_back(mk(1, 0, 0, 0, 0, 0, 8'h00, 1, 1, 1, uw,    "up_wrap"));
      tbl.push_back(mk(1, 0, 0, 0, 0, 1, 8'h5C, 0, 1, 0, 8'h59, "ld_clamp"));
      tbl.push_back(mk(1, 0, 0, 0, 0, 1, 8'h21, 1, 1, 0, 8'h21, "ld_wins"));
      tbl.push_back(mk(1, 0, 0, 1, 0, 0, 8'h00, 0, 1, 0, 8'h21, "r9_single"));
      tbl.push_back(mk(1, 0, 0, 1, 1, 1, 8'h12, 0, 1, 0, 8'h99, "set_beats_ld"));
      tbl.push_back(mk(1, 1, 1, 0, 0, 1, 8'h12, 1, 1, 1, 8'h00, "clr_beats_ld"));
      tbl.push_back(mk(1, 0, 0, 0, 0, 1, 8'hFF, 0, 1, 0, 8'h99, "ld_clamp2"));
      tbl.push_back(mk(1, 0, 0, 0, 0, 1, 8'h19, 0, 1, 0, 8'h19, "ld19"));
      tbl.push_back(mk(1, 0, 0, 0, 0, 0, 8'h00, 1, 1, 0, 8'h20, "up_digit1"));
      tbl.push_back(mk(1, 0, 0, 0, 0, 0, 8'h00, 1, 0, 0, 8'h19, "dn_digit1"));
      tbl.push_back(mk(1, 0, 0, 0, 0, 1, 8'h99, 0, 1, 0, 8'h99, "ld99b"));
      tbl.push_back(mk(0, 0, 0, 1, 1, 1, 8'h55, 1, 1, 0, 8'h00, "rst_gate"));
      tbl.push_back(mk(1, 0, 0, 0, 0, 0, 8'h00, 0, 0, 0, 8'h00, "carry_needs_en"));
      tbl.push_back(mk(1, 0, 0, 0, 0, 0, 8'h00, 1, 1, 0, 8'h01, "up_from0"));

      repeat (2) @(posedge clk);

      step_a(mk(0, 0, 0, 0, 0, 0, 8'h00, 1, 1, 0, 8'h00, "reset"));
      check("reset_b", count_b, 12'h000);

      for (int i = 0; i < 100; i++) begin
         step_a(mk(1, 0, 0, 0, 0, 0, 8'h00, 1, 1, (i == 99),
                   (SAT && i == 99) ? 8'h99 : bcd2((i + 1) % 100), "up_seq"));
      end

      for (int i = 0; i < tbl.size(); i++) begin
         step_a(tbl[i]);
      end

      // Modulo-6 three-digit chain: full count cycle, saturation/wrap, mid-count reset, down wrap.
      step_b(1'b0, 1'b1, 1'b1, 1'b0, 12'h000, "b_reset");
      mb = 0;
      for (int i = 0; i < 221; i++) begin
         step_b(1'b1, 1'b1, 1'b1, (mb == 215), pack6(next_b(mb, 1'b1)), "b_up");
         mb = next_b(mb, 1'b1);
      end
      step_b(1'b0, 1'b1, 1'b1, 1'b0, 12'h000, "b_midrst");
      bw  = SAT ? 12'h000 : 12'h555;
      bw2 = SAT ? 12'h000 : 12'h554;
      step_b(1'b1, 1'b1, 1'b0, 1'b1, bw, "b_dn_wrap");
      step_b(1'b1, 1'b1, 1'b0, SAT, bw2, "b_dn_next");

      check("sb_drained", 12'(sb_q.size()), 12'h000);
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
